// File: rtl/register_rxd.sv
// register_rxd: finds the FF×4 preamble in UART RX bytes, buffers the 10-byte tank-state
// payload, validates it and commits all enemy/status registers in a single cycle.
module register_rxd #(
  parameter int          BYTE_TIMEOUT = 40000,
  parameter logic [19:0] LINK_TIMEOUT = 20'd800000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic [9:0] xpos_tank_enemy,
  output logic [9:0] ypos_tank_enemy,
  output logic [9:0] xpos_bullet_enemy,
  output logic [9:0] ypos_bullet_enemy,
  output logic [7:0] hp_our,
  output logic [2:0] direction_for_our,
  output logic       tank_enemy_hit,
  output logic [1:0] direction_tank_enemy,
  output logic       obstacle_hit_enemy,
  output logic       frame_valid,
  output logic       frame_error,
  output logic       link_ok
);
  localparam logic [1:0] SYNC = 2'd0, PAYLOAD = 2'd1, CHECK = 2'd2;
  localparam int GW = $clog2(BYTE_TIMEOUT + 1);
  logic [1:0]    state;
  logic [1:0]    pre_cnt;
  logic [3:0]    idx;
  logic [GW-1:0] gap;
  logic [7:0]    shadow [10];
  logic [19:0]   link_cnt;
  logic          seen;
  logic          timeout;
  logic          good;
  assign timeout = (state == PAYLOAD) && (gap == GW'(BYTE_TIMEOUT));
  assign good = ~|shadow[1][7:2] & ~|shadow[3][7:2] & ~|shadow[5][7:2] & ~|shadow[7][7:2] & ~shadow[9][7];
  assign link_ok = seen && (link_cnt < LINK_TIMEOUT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
      pre_cnt <= '0;
      idx <= '0;
      gap <= '0;
      for (int i = 0; i < 10; i++) shadow[i] <= '0;
      link_cnt <= '0;
      seen <= 1'b0;
      xpos_tank_enemy <= '0;
      ypos_tank_enemy <= '0;
      xpos_bullet_enemy <= '0;
      ypos_bullet_enemy <= '0;
      hp_our <= '0;
      direction_for_our <= '0;
      tank_enemy_hit <= 1'b0;
      direction_tank_enemy <= '0;
      obstacle_hit_enemy <= 1'b0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      link_cnt <= (state == CHECK && good) ? '0 : (link_cnt == LINK_TIMEOUT) ? link_cnt : link_cnt + 20'd1;
      case (state)
        SYNC: if (rx_done) begin
          if (rx_data == 8'hFF && pre_cnt == 2'd3) begin
            state <= PAYLOAD;
            pre_cnt <= '0;
            idx <= '0;
            gap <= '0;
          end else begin
            pre_cnt <= (rx_data == 8'hFF) ? pre_cnt + 2'd1 : 2'd0;
          end
        end
        PAYLOAD: begin
          // a timeout beats a byte arriving in the same cycle
          if (timeout) begin
            state <= SYNC;
            frame_error <= 1'b1;
            for (int i = 0; i < 10; i++) shadow[i] <= '0;
          end else if (rx_done) begin
            shadow[idx] <= rx_data;
            idx <= idx + 4'd1;
            gap <= '0;
            if (idx == 4'd9) state <= CHECK;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        CHECK: begin
          state <= SYNC;
          pre_cnt <= '0;
          if (good) begin
            xpos_tank_enemy <= {shadow[1][1:0], shadow[0]};
            ypos_tank_enemy <= {shadow[3][1:0], shadow[2]};
            xpos_bullet_enemy <= {shadow[5][1:0], shadow[4]};
            ypos_bullet_enemy <= {shadow[7][1:0], shadow[6]};
            hp_our <= shadow[8];
            direction_for_our <= shadow[9][3:1];
            tank_enemy_hit <= shadow[9][0];
            direction_tank_enemy <= shadow[9][5:4];
            obstacle_hit_enemy <= shadow[9][6];
            frame_valid <= 1'b1;
            seen <= 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_register_rxd.sv
// tb_register_rxd: table of frames driven byte by byte; a scoreboard queue holds the expected
// commit/discard event for each frame and is drained by a monitor on frame_valid/frame_error.
module tb_register_rxd;
  localparam int          BT  = 1000;
  localparam logic [19:0] LT  = 20'd8000;
  localparam int          GAP = 200;
  typedef struct packed {
    logic ok;
    logic [9:0] x, y, bx, by;
    logic [7:0] hp;
    logic [2:0] df;
    logic th;
    logic [1:0] dt;
    logic ob;
  } out_t;
  typedef struct packed {
    logic [79:0] pay;
    logic noise;
    logic xtra;
    out_t o;
  } vec_t;
  typedef struct packed {
    out_t o;
    logic [31:0] due;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b1, rx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic [9:0] xpos_tank_enemy, ypos_tank_enemy, xpos_bullet_enemy, ypos_bullet_enemy;
  logic [7:0] hp_our;
  logic [2:0] direction_for_our;
  logic tank_enemy_hit, obstacle_hit_enemy, frame_valid, frame_error, link_ok;
  logic [1:0] direction_tank_enemy;
  out_t cur, last;
  exp_t sb[$];
  vec_t v[10];
  int cyc = 0, nc = 0, nf = 0, commit_cyc = 0;
  bit accepted = 1'b0;
  register_rxd #(.BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .xpos_tank_enemy(xpos_tank_enemy), .ypos_tank_enemy(ypos_tank_enemy),
    .xpos_bullet_enemy(xpos_bullet_enemy), .ypos_bullet_enemy(ypos_bullet_enemy),
    .hp_our(hp_our), .direction_for_our(direction_for_our), .tank_enemy_hit(tank_enemy_hit),
    .direction_tank_enemy(direction_tank_enemy), .obstacle_hit_enemy(obstacle_hit_enemy),
    .frame_valid(frame_valid), .frame_error(frame_error), .link_ok(link_ok)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign cur = {frame_valid, xpos_tank_enemy, ypos_tank_enemy, xpos_bullet_enemy, ypos_bullet_enemy,
                hp_our, direction_for_our, tank_enemy_hit, direction_tank_enemy, obstacle_hit_enemy};
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nc++;
    if (a !== e) begin
      nf++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic vec_t mk(logic [79:0] p, bit n, bit xt, bit ok, int x, int y, int bx, int by,
                              int hp, int df, int th, int dt, int ob);
    mk.pay = p; mk.noise = n; mk.xtra = xt; mk.o.ok = ok;
    mk.o.x = 10'(x); mk.o.y = 10'(y); mk.o.bx = 10'(bx); mk.o.by = 10'(by);
    mk.o.hp = 8'(hp); mk.o.df = 3'(df); mk.o.th = 1'(th); mk.o.dt = 2'(dt); mk.o.ob = 1'(ob);
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (frame_valid || frame_error)) begin
      chk("pulse_exclusive", 64'(frame_valid & frame_error), 64'd0);
      if (sb.size() == 0) chk("unexpected_event", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("event_outputs", 64'(cur), 64'(e.o));
        if (e.due != 0) chk("commit_latency", 64'(cyc), 64'(e.due));
        if (frame_valid) commit_cyc = cyc;
      end
    end
  end
  task automatic send_byte(input logic [7:0] d, input bit push, input out_t o, input bit timed, input bit xtra);
    exp_t t;
    @(negedge clk);
    rx_data = d;
    rx_done = 1'b1;
    if (push) begin
      t.o = o;
      t.due = timed ? 32'(cyc + 2) : 32'd0;
      sb.push_back(t);
    end
    if (xtra) begin
      @(negedge clk);
      rx_data = 8'hFF;
    end
    @(negedge clk);
    rx_done = 1'b0;
    repeat (GAP - 1) @(negedge clk);
  endtask
  task automatic send_frame(input vec_t f);
    out_t o;
    if (f.noise) foreach (f.pay[i]) if (i < 4) send_byte(i == 0 ? 8'h00 : i == 3 ? 8'h12 : 8'hFF, 0, '0, 0, 0);
    repeat (4) send_byte(8'hFF, 0, '0, 0, 0);
    for (int i = 0; i < 9; i++) send_byte(f.pay[79-8*i -: 8], 0, '0, 0, 0);
    o = last;
    if (f.o.ok) begin
      o = f.o;
      last = f.o;
      last.ok = 1'b0;
      accepted = 1'b1;
    end
    send_byte(f.pay[7:0], 1, o, 1, f.xtra);
    chk("outputs_after_frame", 64'(cur), 64'(last));
    chk("link_ok_after_frame", 64'(link_ok), 64'(accepted));
  endtask
  initial begin
    #1500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    v[0] = mk(80'h2C01_6400_1002_2003_505B, 0, 0, 1, 300, 100, 528, 800, 8'h50, 5, 1, 1, 1);
    v[1] = mk(80'hFF03_0A00_0500_0700_6400, 0, 0, 1, 1023, 10, 5, 7, 8'h64, 0, 0, 0, 0);
    v[2] = mk(80'h1105_2200_3300_4400_0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[3] = mk(80'h3402_7801_9A00_BC03_0C26, 1, 0, 1, 564, 376, 154, 956, 8'h0C, 3, 0, 2, 0);
    v[4] = mk(80'h0100_0200_0300_0400_0580, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[5] = mk(80'hFF03_FF03_FF03_FF03_FF7F, 0, 1, 1, 1023, 1023, 1023, 1023, 8'hFF, 7, 1, 3, 1);
    v[6] = mk(80'h0000_0000_0000_0008_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[7] = mk(80'h0000_0000_0000_0000_0001, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    v[8] = mk(80'h0000_0040_0000_0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[9] = mk(80'h0000_0000_00FC_0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    last = '0;
    #2 rst_n = 1'b0;
    #20;
    chk("reset_outputs", 64'(cur), 64'd0);
    chk("reset_frame_error", 64'(frame_error), 64'd0);
    chk("reset_link_ok", 64'(link_ok), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) send_frame(v[i]);
    // six payload bytes, then silence past the gap timeout
    repeat (4) send_byte(8'hFF, 0, '0, 0, 0);
    for (int i = 0; i < 6; i++) send_byte(v[5].pay[79-8*i -: 8], i == 5, last, 0, 0);
    repeat (BT + 50) @(negedge clk);
    chk("timeout_event_seen", 64'(sb.size()), 64'd0);
    chk("outputs_after_timeout", 64'(cur), 64'(last));
    send_frame(v[0]);
    // reset in the middle of a payload
    repeat (4) send_byte(8'hFF, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) send_byte(8'h55, 0, '0, 0, 0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("reset_mid_payload", 64'(cur), 64'd0);
    chk("reset_mid_link_ok", 64'(link_ok), 64'd0);
    last = '0;
    accepted = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("link_ok_before_first_frame", 64'(link_ok), 64'd0);
    send_frame(v[3]);
    while (cyc < commit_cyc + int'(LT) - 5) @(negedge clk);
    chk("link_ok_before_watchdog", 64'(link_ok), 64'd1);
    while (cyc < commit_cyc + int'(LT) + 5) @(negedge clk);
    chk("link_ok_after_watchdog", 64'(link_ok), 64'd0);
    chk("outputs_hold_after_watchdog", 64'(cur), 64'(last));
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule

// File: doc/register_rxd.md
Name: register_rxd

Overview:
- Receive-side counterpart of the tank-state UART link: takes bytes from the UART receiver, finds the 4-byte 0xFF preamble, and collects the 10-byte payload.
- Validates the frame, then updates the enemy tank, bullet and status registers together in one cycle for the game logic.
- Sits between the UART RX core and the enemy-tank and hit-logic blocks.

Parameters:
- BYTE_TIMEOUT, 40000, maximum clk cycles allowed between bytes inside a frame before the frame is abandoned (one byte takes about 18621 cycles).
- LINK_TIMEOUT, 20'd800000, cycles with no accepted frame before link_ok drops.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_done  in  1  one-cycle strobe from the UART RX core; rx_data is valid in that cycle
- rx_data  in  8  received byte
- xpos_tank_enemy  out  10  enemy tank x
- ypos_tank_enemy  out  10  enemy tank y
- xpos_bullet_enemy  out  10  enemy bullet x
- ypos_bullet_enemy  out  10  enemy bullet y
- hp_our  out  8  our hp as computed by the peer
- direction_for_our  out  3  direction field from the flags byte
- tank_enemy_hit  out  1  flags bit0
- direction_tank_enemy  out  2  flags bits5:4
- obstacle_hit_enemy  out  1  flags bit6
- frame_valid  out  1  one-cycle pulse when a frame is committed
- frame_error  out  1  one-cycle pulse when a frame is discarded
- link_ok  out  1  high while frames arrive within LINK_TIMEOUT

Behaviour:
- Reset is asynchronous; all outputs go to 0, state SYNC, counters cleared.
- Frame byte order (14 bytes): FF FF FF FF, xlo, xhi, ylo, yhi, bxlo, bxhi, bylo, byhi, hp, flags.
- Each 10-bit value = {hi[1:0], lo}.
- Flags byte = {0, obstacle, dir_tank[1:0], dir_for[2:0], tank_hit}.
- All state changes happen only on cycles where rx_done=1, except the timeout handling below.
- States:
  - SYNC:
    - rx_done with 0xFF: pre_cnt++.
    - rx_done with any other byte: pre_cnt=0.
    - When pre_cnt reaches 4: go to PAYLOAD, idx=0, gap counter cleared.
  - PAYLOAD:
    - Each rx_done stores rx_data into a shadow buffer at idx, then idx++. The byte after the 4th FF is taken as xlo even if it is 0xFF; the preamble is never extended.
    - On the byte with idx=9: go to CHECK.
  - CHECK (one cycle):
    - Frame is valid iff xhi, yhi, bxhi, byhi all have bits7:2 == 0 and flags bit7 == 0.
    - Valid: all outputs load from the shadow buffer in the same clock edge; frame_valid=1 for one cycle.
    - Invalid: outputs hold; frame_error=1 for one cycle.
    - Either way: go to SYNC with pre_cnt=0.
- Latency: outputs update 2 clk after the rx_done of the flags byte (1 cycle to store, 1 cycle in CHECK).
- Gap timeout:
  - In PAYLOAD a gap counter increments every cycle and clears on rx_done.
  - When it reaches BYTE_TIMEOUT: frame_error pulses, state goes to SYNC, shadow buffer is discarded, outputs hold.
  - If rx_done arrives in the same cycle as the timeout, the timeout wins and the byte is dropped.
- Link watchdog:
  - Counter clears on frame_valid; otherwise increments and saturates at LINK_TIMEOUT.
  - link_ok = (counter < LINK_TIMEOUT) AND at least one frame has been accepted since reset.
- Outputs never show a partial frame; the shadow buffer is the only thing written during PAYLOAD.
- rx_done asserted during CHECK: the byte is ignored.
- Reset asserted mid-frame: state, shadow buffer and outputs all clear immediately.

Test Plan:
- Basic frame: FF×4, 0x2C, 0x01, 0x64, 0x00, 0x10, 0x02, 0x20, 0x03, 0x50, 0x5B with a 200-cycle byte gap.
  - Expected: xpos=300, ypos=100, bx=528, by=800, hp=0x50, obstacle=1, dir_tank=1, dir_for=5, tank_hit=1, frame_valid pulses once, link_ok=1.
- Resync after noise: 0x12, FF, FF, 0x00, then a full valid frame.
  - Expected: exactly one frame_valid, and the outputs match the second frame.
- xlo=0xFF: FF×4, then FF, 0x03, ... (rest valid).
  - Expected: xpos_tank_enemy=1023, no misalignment.
- Corrupt hi byte: xhi=0x05.
  - Expected: frame_error pulses, outputs keep their previous values, the next valid frame is accepted.
- Gap timeout: stop after 6 payload bytes for BYTE_TIMEOUT cycles, then send a new full frame.
  - Expected: frame_error on the timeout, the new frame is committed correctly.
- Reset and watchdog:
  - Assert rst_n=0 mid-payload → all outputs 0 immediately.
  - After release, send no frames for LINK_TIMEOUT cycles after one valid frame → link_ok falls to 0.
